// File: rtl/fuzz_drv_pkg.sv
// Shared types and helpers for the sha256 fuzz bus driver.
package fuzz_drv_pkg;

  localparam int unsigned REC_W      = 64;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CMD_ADDR_W = 31;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } drv_state_e;

  typedef struct packed {
    logic                  is_read;
    logic [CMD_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } cmd_t;

  // Fuzz records arrive little-endian per 32-bit field.
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/fuzz_drv_fifo.sv
// Synchronous command FIFO holding decoded bus commands; full/empty from
// extra-MSB wrapping pointers.
module fuzz_drv_fifo
  import fuzz_drv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fuzz_bus_driver.sv
// Drives buffered fuzz records onto the sha256 cs/we register bus, one
// transaction per record, and returns one response per record.
// Build option: define FUZZ_DRV_ERRCNT_EN to add the err_count output.
module fuzz_bus_driver
  import fuzz_drv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rec_valid,
  output logic              rec_ready,
  input  logic [REC_W-1:0]  rec_data,
  output logic              cs,
  output logic              we,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic              error,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_is_read,
  output logic              busy
`ifdef FUZZ_DRV_ERRCNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  logic [31:0] addr_sw;
  logic [31:0] data_sw;
  cmd_t        cmd_in;
  cmd_t        fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        unused_addr_hi;

  drv_state_e  state_q;
  drv_state_e  state_d;
  logic        is_read_q;
  logic        cs_d;
  logic        we_d;
  logic        capture_rsp;
  logic        rsp_clear;

  // Record decode: byte swap both fields, bit 31 of the address selects read.
  assign addr_sw = bswap32(rec_data[63:32]);
  assign data_sw = bswap32(rec_data[31:0]);

  always_comb begin
    cmd_in         = '0;
    cmd_in.is_read = addr_sw[31];
    cmd_in.addr    = addr_sw[30:0];
    cmd_in.data    = data_sw;
  end

  assign rec_ready = !fifo_full;
  assign push      = rec_valid && rec_ready;
  assign busy      = !fifo_empty || (state_q != IDLE);

  // Address bits above ADDR_W are carried but deliberately ignored.
  assign unused_addr_hi = ^fifo_dout.addr;

  fuzz_drv_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (cmd_in),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    cs_d        = 1'b0;
    we_d        = 1'b0;
    capture_rsp = 1'b0;
    rsp_clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = ISSUE;
          pop     = 1'b1;
          cs_d    = 1'b1;
          we_d    = !fifo_dout.is_read;
        end
      end
      ISSUE: begin
        state_d     = RESP;
        capture_rsp = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d   = IDLE;
          rsp_clear = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command register doubles as the bus address/data drivers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs         <= 1'b0;
      we         <= 1'b0;
      address    <= '0;
      write_data <= '0;
      is_read_q  <= 1'b0;
    end else begin
      cs <= cs_d;
      we <= we_d;
      if (pop) begin
        address    <= fifo_dout.addr[ADDR_W-1:0];
        write_data <= fifo_dout.data;
        is_read_q  <= fifo_dout.is_read;
      end
    end
  end

  // Response is captured as the bus cycle ends and held until accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_is_read <= 1'b0;
    end else begin
      if (capture_rsp) begin
        rsp_valid   <= 1'b1;
        rsp_data    <= is_read_q ? read_data : '0;
        rsp_err     <= error;
        rsp_is_read <= is_read_q;
      end else if (rsp_clear) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef FUZZ_DRV_ERRCNT_EN
  // Saturating count of bus cycles that reported an error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if ((state_q == ISSUE) && error && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
